mem_copy_engine: RTL

- Bus-initiator counterpart to the team's byte-wide data memory. Drives that memory's Address/WriteData/MemRead/MemWrite and samples its ReadData.
- Copies a block of `length` bytes from `src_base` to `dst_base`, one byte at a time (read, then write).
- Accumulates a mod-256 checksum of the bytes moved.
- Sits beside the datapath as a simple DMA helper, started by a one-cycle `start` pulse.

---
 rtl/mem_copy_engine.sv | 72 +++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: byte-at-a-time block copy between two regions of a byte-wide memory,
// accumulating a mod-2^DATA_W checksum of the bytes moved.
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] ReadData
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] src_ptr, dst_ptr, remaining;
  logic [DATA_W-1:0] latch;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (length == '0) ? DONE : READ;
      READ:    state_nx = WRITE;
      WRITE:   state_nx = (remaining == ADDR_W'(1)) ? DONE : READ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      latch     <= '0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src_ptr   <= src_base;
          dst_ptr   <= dst_base;
          remaining <= length;
          sum       <= '0;
        end
        READ: begin
          latch   <= ReadData;
          sum     <= sum + ReadData;
          src_ptr <= src_ptr + ADDR_W'(1);
        end
        WRITE: begin
          dst_ptr   <= dst_ptr + ADDR_W'(1);
          remaining <= remaining - ADDR_W'(1);
        end
        default: ;
      endcase
    end
  // Bus outputs decode straight from state so an async reset drops them at once.
  assign busy      = (state == READ) || (state == WRITE);
  assign done      = state == DONE;
  assign MemRead   = state == READ;
  assign MemWrite  = state == WRITE;
  assign Address   = (state == READ) ? src_ptr : (state == WRITE) ? dst_ptr : '0;
  assign WriteData = (state == WRITE) ? latch : '0;
endmodule
